// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operator codes, FSM states, widths.
// Imported by calc_seq_ctrl and by anything that decodes its operator field.
package calc_pkg;

  localparam int CALC_W_IN  = 4;
  localparam int CALC_W_OUT = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    EXEC   = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic is_div_zero(input logic [1:0] op_code, input logic b_is_zero);
    return (op_code == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: gathers A/op/B keypad pulses, drives the ALU for ALU_LAT cycles, latches the result.
// Latency eq->result = ALU_LAT cycles; no backpressure, pulses arriving in EXEC are dropped; CALC_CHAIN_EN enables result chaining.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int W_IN    = CALC_W_IN,
  parameter int W_OUT   = CALC_W_OUT,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             digit_valid,
  input  logic [W_IN-1:0]  digit,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic             eq,
  input  logic             clr,
  output logic [W_IN-1:0]  alu_i1,
  output logic [W_IN-1:0]  alu_i2,
  output logic [1:0]       alu_ctrl,
  input  logic [W_OUT-1:0] alu_o,
  output logic [W_OUT-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  state_t           state_q, state_d;
  logic [W_IN-1:0]  a_q, a_d;
  logic [W_IN-1:0]  b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [W_OUT-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

  // Event priority clr > eq > op_valid > digit_valid: only the winner is considered per state.
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = err_q;
    cnt_d          = cnt_q;

    if (clr) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!eq && !op_valid && digit_valid) begin
            a_d     = digit;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (!eq) begin
            if (op_valid) begin
              op_d    = op;
              state_d = GOT_OP;
            end else if (digit_valid) begin
              a_d = digit;
            end
          end
        end
        GOT_OP: begin
          if (!eq) begin
            if (op_valid) begin
              op_d = op;
            end else if (digit_valid) begin
              b_d     = digit;
              state_d = GOT_B;
            end
          end
        end
        GOT_B: begin
          if (eq) begin
            if (is_div_zero(op_q, b_q == '0)) begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = DONE;
            end else begin
              cnt_d   = CNT_W'(ALU_LAT);
              state_d = EXEC;
            end
          end else if (!op_valid && digit_valid) begin
            b_d = digit;
          end
        end
        EXEC: begin
          if (cnt_q == CNT_W'(1)) begin
            result_d       = alu_o;
            result_valid_d = 1'b1;
            cnt_d          = '0;
            state_d        = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (!eq) begin
            if (op_valid) begin
`ifdef CALC_CHAIN_EN
              // Chaining is only legal when the previous result fits in an operand.
              if (result_q[W_OUT-1:W_IN] == '0) begin
                a_d     = result_q[W_IN-1:0];
                op_d    = op;
                err_d   = 1'b0;
                state_d = GOT_OP;
              end else begin
                err_d = 1'b1;
              end
`endif
            end else if (digit_valid) begin
              a_d     = digit;
              err_d   = 1'b0;
              state_d = GOT_A;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == EXEC);
  end

  assign alu_i1       = a_q;
  assign alu_i2       = b_q;
  assign alu_ctrl     = op_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: two instances (ALU_LAT=1 and 3) share keypad stimulus, each with its own ALU model.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       op_valid;
  logic [1:0] op;
  logic       eq;
  logic       clr;

  logic [3:0] a1_i1, a1_i2, a3_i1, a3_i2;
  logic [1:0] a1_ctrl, a3_ctrl;
  logic [6:0] a1_o, a3_o, res1, res3;
  logic       rv1, rv3, busy1, busy3, err1, err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] alu_model(input logic [3:0] i1, input logic [3:0] i2, input logic [1:0] c);
    logic [7:0] r;
    case (c)
      2'b00:   r = {4'd0, i1} + {4'd0, i2};
      2'b01:   r = {4'd0, i1} - {4'd0, i2};
      2'b10:   r = {4'd0, i1} * {4'd0, i2};
      default: r = (i2 == 4'd0) ? 8'd0 : {4'd0, i1 / i2};
    endcase
    return r[6:0];
  endfunction

  assign a1_o = alu_model(a1_i1, a1_i2, a1_ctrl);
  assign a3_o = alu_model(a3_i1, a3_i2, a3_ctrl);

  calc_seq_ctrl #(.W_IN(4), .W_OUT(7), .ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op(op), .eq(eq), .clr(clr),
    .alu_i1(a1_i1), .alu_i2(a1_i2), .alu_ctrl(a1_ctrl), .alu_o(a1_o),
    .result(res1), .result_valid(rv1), .busy(busy1), .err(err1)
  );

  calc_seq_ctrl #(.W_IN(4), .W_OUT(7), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op(op), .eq(eq), .clr(clr),
    .alu_i1(a3_i1), .alu_i2(a3_i2), .alu_ctrl(a3_ctrl), .alu_o(a3_o),
    .result(res3), .result_valid(rv3), .busy(busy3), .err(err3)
  );

  task automatic pulse_digit(input logic [3:0] d);
    @(negedge clk); digit_valid = 1'b1; digit = d;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic pulse_op(input logic [1:0] o);
    @(negedge clk); op_valid = 1'b1; op = o;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic pulse_eq();
    @(negedge clk); eq = 1'b1;
    @(negedge clk); eq = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({res1, rv1, busy1, err1, a1_i1, a1_i2, a1_ctrl} !== 22'd0) begin
      failures++; $display("FAIL reset_outputs_lat1 got=%h exp=0", {res1, rv1, busy1, err1, a1_i1, a1_i2, a1_ctrl});
    end
    checks++;
    if ({res3, rv3, busy3, err3, a3_i1, a3_i2, a3_ctrl} !== 22'd0) begin
      failures++; $display("FAIL reset_outputs_lat3 got=%h exp=0", {res3, rv3, busy3, err3, a3_i1, a3_i2, a3_ctrl});
    end
    checks++;
    if (u_lat3.state_q !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", u_lat3.state_q, IDLE);
    end
  endtask

  task automatic test_add();
    int b1, b3, r1, r3, ri1, ri3;
    b1 = 0; b3 = 0; r1 = 0; r3 = 0; ri1 = -1; ri3 = -1;
    pulse_digit(4'd6); pulse_op(OP_ADD); pulse_digit(4'd2);
    checks++;
    if ({a1_i1, a1_i2, a1_ctrl} !== {4'd6, 4'd2, 2'b00}) begin
      failures++; $display("FAIL add_alu_inputs got=%h exp=%h", {a1_i1, a1_i2, a1_ctrl}, {4'd6, 4'd2, 2'b00});
    end
    pulse_eq();
    for (int k = 0; k < 6; k++) begin
      if (busy1) b1++;
      if (busy3) b3++;
      if (rv1) begin r1++; ri1 = k; end
      if (rv3) begin r3++; ri3 = k; end
      @(negedge clk);
    end
    checks++;
    if (b1 !== 1) begin failures++; $display("FAIL add_busy_cycles_lat1 got=%0d exp=1", b1); end
    checks++;
    if (r1 !== 1 || ri1 !== 1) begin failures++; $display("FAIL add_rv_lat1 got count=%0d at=%0d exp count=1 at=1", r1, ri1); end
    checks++;
    if (res1 !== 7'd8) begin failures++; $display("FAIL add_result_lat1 got=%0d exp=8", res1); end
    checks++;
    if (b3 !== 3) begin failures++; $display("FAIL add_busy_cycles_lat3 got=%0d exp=3", b3); end
    checks++;
    if (r3 !== 1 || ri3 !== 3) begin failures++; $display("FAIL add_rv_lat3 got count=%0d at=%0d exp count=1 at=3", r3, ri3); end
    checks++;
    if (res3 !== 7'd8) begin failures++; $display("FAIL add_result_lat3 got=%0d exp=8", res3); end
  endtask

  task automatic test_clr_exec();
    int r3;
    r3 = 0;
    pulse_digit(4'd6); pulse_op(OP_SUB); pulse_digit(4'd2);
    pulse_eq();
    checks++;
    if (busy3 !== 1'b1) begin failures++; $display("FAIL clr_exec_busy_before got=%b exp=1", busy3); end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rv3) r3++;
      @(negedge clk);
    end
    checks++;
    if (busy3 !== 1'b0 || r3 !== 0) begin failures++; $display("FAIL clr_exec_abort got busy=%b rv=%0d exp busy=0 rv=0", busy3, r3); end
    checks++;
    if (res3 !== 7'd8) begin failures++; $display("FAIL clr_exec_result_kept got=%0d exp=8", res3); end
    checks++;
    if ({a3_i1, a3_i2, a3_ctrl} !== 10'd0) begin failures++; $display("FAIL clr_exec_regs got=%h exp=0", {a3_i1, a3_i2, a3_ctrl}); end
    checks++;
    if (u_lat3.state_q !== IDLE) begin failures++; $display("FAIL clr_exec_state got=%0d exp=%0d", u_lat3.state_q, IDLE); end
  endtask

  task automatic test_mul_ignore();
    int b3, r3;
    b3 = 0; r3 = 0;
    pulse_digit(4'd6); pulse_op(OP_MUL); pulse_digit(4'd2);
    pulse_eq();
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin digit_valid = 1'b1; digit = 4'd9; end
      if (k == 2) digit_valid = 1'b0;
      if (busy3) b3++;
      if (rv3) r3++;
      @(negedge clk);
    end
    checks++;
    if (b3 !== 3 || r3 !== 1) begin failures++; $display("FAIL mul_busy_rv got busy=%0d rv=%0d exp busy=3 rv=1", b3, r3); end
    checks++;
    if (res3 !== 7'd12) begin failures++; $display("FAIL mul_result got=%0d exp=12", res3); end
    checks++;
    if (a3_i1 !== 4'd6 || u_lat3.state_q !== DONE) begin
      failures++; $display("FAIL mul_digit_ignored got A=%0d state=%0d exp A=6 state=%0d", a3_i1, u_lat3.state_q, DONE);
    end
  endtask

  task automatic test_div_zero();
    int b, r;
    b = 0; r = 0;
    pulse_digit(4'd6); pulse_op(OP_DIV); pulse_digit(4'd0);
    pulse_eq();
    for (int k = 0; k < 4; k++) begin
      if (busy1 || busy3) b++;
      if (rv1 || rv3) r++;
      @(negedge clk);
    end
    checks++;
    if (b !== 0 || r !== 0) begin failures++; $display("FAIL div0_no_exec got busy=%0d rv=%0d exp 0 0", b, r); end
    checks++;
    if ({err1, err3} !== 2'b11 || res3 !== 7'd0 || res1 !== 7'd0) begin
      failures++; $display("FAIL div0_err got err=%b%b res3=%0d exp err=11 res3=0", err1, err3, res3);
    end
    checks++;
    if (u_lat3.state_q !== DONE) begin failures++; $display("FAIL div0_state got=%0d exp=%0d", u_lat3.state_q, DONE); end
    pulse_digit(4'd4);
    checks++;
    if (err3 !== 1'b0 || u_lat3.state_q !== GOT_A || a3_i1 !== 4'd4) begin
      failures++; $display("FAIL div0_recover got err=%b state=%0d A=%0d exp err=0 state=%0d A=4", err3, u_lat3.state_q, a3_i1, GOT_A);
    end
  endtask

  task automatic test_priority();
    @(negedge clk); clr = 1'b1; digit_valid = 1'b1; digit = 4'd5;
    @(negedge clk); clr = 1'b0; digit_valid = 1'b0;
    checks++;
    if (a3_i1 !== 4'd0 || u_lat3.state_q !== IDLE) begin
      failures++; $display("FAIL prio_clr_digit got A=%0d state=%0d exp A=0 state=%0d", a3_i1, u_lat3.state_q, IDLE);
    end
    pulse_digit(4'd7);
    @(negedge clk); op_valid = 1'b1; op = OP_SUB; digit_valid = 1'b1; digit = 4'd3;
    @(negedge clk); op_valid = 1'b0; digit_valid = 1'b0;
    checks++;
    if (u_lat3.state_q !== GOT_OP || a3_ctrl !== OP_SUB || a3_i1 !== 4'd7) begin
      failures++; $display("FAIL prio_op_digit got state=%0d op=%0d A=%0d exp state=%0d op=1 A=7", u_lat3.state_q, a3_ctrl, a3_i1, GOT_OP);
    end
  endtask

  task automatic test_done_op();
    pulse_clr();
    pulse_digit(4'd6); pulse_op(OP_ADD); pulse_digit(4'd2);
    pulse_eq();
    repeat (5) @(negedge clk);
    pulse_op(OP_SUB);
`ifdef CALC_CHAIN_EN
    checks++;
    if (u_lat3.state_q !== GOT_OP || a3_i1 !== 4'd8 || a1_i1 !== 4'd8) begin
      failures++; $display("FAIL chain_take got state=%0d A=%0d exp state=%0d A=8", u_lat3.state_q, a3_i1, GOT_OP);
    end
    pulse_digit(4'd3);
    pulse_eq();
    repeat (5) @(negedge clk);
    checks++;
    if (res3 !== 7'd5 || res1 !== 7'd5) begin failures++; $display("FAIL chain_result got=%0d exp=5", res3); end
    pulse_digit(4'd15); pulse_op(OP_MUL); pulse_digit(4'd15);
    pulse_eq();
    repeat (5) @(negedge clk);
    checks++;
    if (res3 !== 7'd97) begin failures++; $display("FAIL chain_mul_result got=%0d exp=97", res3); end
    pulse_op(OP_ADD);
    checks++;
    if (err3 !== 1'b1 || u_lat3.state_q !== DONE) begin
      failures++; $display("FAIL chain_overflow got err=%b state=%0d exp err=1 state=%0d", err3, u_lat3.state_q, DONE);
    end
`else
    checks++;
    if (u_lat3.state_q !== DONE || a3_ctrl !== OP_ADD || err3 !== 1'b0 || res3 !== 7'd8) begin
      failures++; $display("FAIL done_op_ignored got state=%0d op=%0d err=%b res=%0d exp state=%0d op=0 err=0 res=8",
                           u_lat3.state_q, a3_ctrl, err3, res3, DONE);
    end
`endif
    pulse_eq();
    checks++;
    if (busy3 !== 1'b0 || u_lat3.state_q !== DONE) begin
      failures++; $display("FAIL done_eq_ignored got busy=%b state=%0d exp busy=0 state=%0d", busy3, u_lat3.state_q, DONE);
    end
  endtask

  task automatic test_reset_mid_exec();
    pulse_digit(4'd5); pulse_op(OP_ADD); pulse_digit(4'd5);
    pulse_eq();
    checks++;
    if (busy3 !== 1'b1) begin failures++; $display("FAIL rst_exec_busy_before got=%b exp=1", busy3); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res3, rv3, busy3, err3, a3_i1, a3_i2, a3_ctrl} !== 22'd0) begin
      failures++; $display("FAIL rst_exec_async got=%h exp=0", {res3, rv3, busy3, err3, a3_i1, a3_i2, a3_ctrl});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u_lat3.state_q !== IDLE || busy3 !== 1'b0 || res1 !== 7'd0) begin
      failures++; $display("FAIL rst_exec_release got state=%0d busy=%b exp state=%0d busy=0", u_lat3.state_q, busy3, IDLE);
    end
  endtask

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit = '0; op_valid = 1'b0; op = '0; eq = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_clr_exec();
    test_mul_ignore();
    test_div_zero();
    test_priority();
    test_done_op();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
